// File: rtl/scarv_cop_insn_rsp.sv
`default_nettype none
// =============================================================================
// Module   : scarv_cop_insn_rsp
// Brief    : XCrypto COP-side instruction responder. It filters illegal opcodes,
//            dispatches legal instructions to the execution unit and holds the
//            result on the response channel until the CPU acknowledges it.
//            Optional macro SCARV_COP_INSN_TIMEOUT_EN adds an EXEC-state timeout.
// Revision : 1.0 - initial release
// =============================================================================
module scarv_cop_insn_rsp #(
  parameter logic [6:0]  OPCODE_MATCH   = 7'b0001011,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        g_clk,
  input  logic        g_reset,
  input  logic        cpu_insn_req,
  output logic        cop_insn_ack,
  input  logic [31:0] cpu_insn_enc,
  input  logic [31:0] cpu_rs1,
  output logic        cop_wen,
  output logic [4:0]  cop_waddr,
  output logic [31:0] cop_wdata,
  output logic [2:0]  cop_result,
  output logic        cop_insn_rsp,
  input  logic        cpu_insn_ack,
  output logic        id_valid,
  output logic [31:0] id_enc,
  output logic [31:0] id_rs1,
  input  logic        id_ready,
  input  logic        ex_done,
  input  logic        ex_wen,
  input  logic [31:0] ex_wdata,
  input  logic [2:0]  ex_result,
  output logic        ex_abort
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DISPATCH = 2'd1,
    ST_EXEC     = 2'd2,
    ST_RESP     = 2'd3
  } state_t;

  localparam logic [2:0] RESULT_ILLEGAL = 3'b010;
  localparam logic [2:0] RESULT_OK      = 3'b000;

  if ((TIMEOUT_CYCLES < 1) || (TIMEOUT_CYCLES > 65535)) begin : g_timeout_range_check
    $error("scarv_cop_insn_rsp: TIMEOUT_CYCLES must be in 1..65535");
  end

  state_t      state_q,  state_d;
  logic [31:0] enc_q,    enc_d;
  logic [31:0] rs1_q,    rs1_d;
  logic        wen_q,    wen_d;
  logic [31:0] wdata_q,  wdata_d;
  logic [2:0]  result_q, result_d;
  logic        legal_op;
  logic        active;
  logic        in_resp;

`ifdef SCARV_COP_INSN_TIMEOUT_EN
  localparam logic [2:0] RESULT_TIMEOUT = 3'b111;

  logic [15:0] cnt_q, cnt_d;
  logic        abort_q, abort_d;
  logic        expired;

  assign expired = (cnt_q == 16'(TIMEOUT_CYCLES - 1));
`endif

  assign legal_op = (cpu_insn_enc[6:0] == OPCODE_MATCH);

  always_comb begin
    state_d  = state_q;
    enc_d    = enc_q;
    rs1_d    = rs1_q;
    wen_d    = wen_q;
    wdata_d  = wdata_q;
    result_d = result_q;
`ifdef SCARV_COP_INSN_TIMEOUT_EN
    cnt_d    = cnt_q;
    abort_d  = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (cpu_insn_req) begin
          enc_d = cpu_insn_enc;
          rs1_d = cpu_rs1;
          if (legal_op) begin
            state_d = ST_DISPATCH;
          end else begin
            // Illegal opcodes never reach the execution unit.
            state_d  = ST_RESP;
            wen_d    = 1'b0;
            wdata_d  = 32'd0;
            result_d = RESULT_ILLEGAL;
          end
        end
      end
      ST_DISPATCH: begin
        if (id_ready) begin
          state_d = ST_EXEC;
`ifdef SCARV_COP_INSN_TIMEOUT_EN
          cnt_d   = 16'd0;
`endif
        end
      end
      ST_EXEC: begin
        if (ex_done) begin
          state_d  = ST_RESP;
          wen_d    = ex_wen;
          wdata_d  = ex_wdata;
          result_d = ex_result;
`ifdef SCARV_COP_INSN_TIMEOUT_EN
        end else if (expired) begin
          // Completion in the expiry cycle is taken above, so no abort then.
          state_d  = ST_RESP;
          abort_d  = 1'b1;
          wen_d    = 1'b0;
          wdata_d  = 32'd0;
          result_d = RESULT_TIMEOUT;
        end else begin
          cnt_d = cnt_q + 16'd1;
`endif
        end
      end
      ST_RESP: begin
        if (cpu_insn_ack) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge g_clk) begin
    if (g_reset) begin
      state_q  <= ST_IDLE;
      enc_q    <= 32'd0;
      rs1_q    <= 32'd0;
      wen_q    <= 1'b0;
      wdata_q  <= 32'd0;
      result_q <= 3'd0;
`ifdef SCARV_COP_INSN_TIMEOUT_EN
      cnt_q    <= 16'd0;
      abort_q  <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      enc_q    <= enc_d;
      rs1_q    <= rs1_d;
      wen_q    <= wen_d;
      wdata_q  <= wdata_d;
      result_q <= result_d;
`ifdef SCARV_COP_INSN_TIMEOUT_EN
      cnt_q    <= cnt_d;
      abort_q  <= abort_d;
`endif
    end
  end

  // Every output is forced low while reset is asserted, whatever the state.
  assign active       = !g_reset;
  assign in_resp      = active && (state_q == ST_RESP);

  assign cop_insn_ack = active && (state_q == ST_IDLE);
  assign id_valid     = active && (state_q == ST_DISPATCH);
  assign id_enc       = active ? enc_q : 32'd0;
  assign id_rs1       = active ? rs1_q : 32'd0;

  assign cop_insn_rsp = in_resp;
  assign cop_waddr    = in_resp ? enc_q[11:7] : 5'd0;
  assign cop_wdata    = in_resp ? wdata_q : 32'd0;
  assign cop_result   = in_resp ? result_q : 3'd0;
  assign cop_wen      = in_resp && wen_q && (result_q == RESULT_OK) && (enc_q[11:7] != 5'd0);

`ifdef SCARV_COP_INSN_TIMEOUT_EN
  assign ex_abort = active && abort_q;
`else
  assign ex_abort = 1'b0;
`endif

endmodule
`default_nettype wire

// File: doc/scarv_cop_insn_rsp.md
Name: scarv_cop_insn_rsp

Overview:
COP-side responder for the XCrypto co-processor instruction interface. It accepts instructions from the CPU-side initiator over the req/ack handshake and filters illegal opcodes. It dispatches legal instructions to the COP execution unit, then holds the result on the response channel until the CPU acknowledges it. It sits between the CPU integration glue and the COP decode/execute datapath.

Parameters:
OPCODE_MATCH, 7'b0001011, major opcode (enc[6:0]) accepted as an XCrypto instruction (custom-0).
TIMEOUT_CYCLES, 255, EXEC-state cycle limit. Used only with SCARV_COP_INSN_TIMEOUT_EN; range 1..65535.

Ports:
g_clk  in  1  clock; all state updates on rising edge
g_reset  in  1  synchronous, active-high reset
cpu_insn_req  in  1  CPU instruction request
cop_insn_ack  out  1  request accepted (ready-style)
cpu_insn_enc  in  32  encoded instruction
cpu_rs1  in  32  RS1 source data
cop_wen  out  1  GPR write enable for response
cop_waddr  out  5  GPR destination address
cop_wdata  out  32  GPR write data
cop_result  out  3  result code: 000 ok, 010 illegal opcode, 111 timeout
cop_insn_rsp  out  1  response valid
cpu_insn_ack  in  1  CPU accepts response
id_valid  out  1  instruction valid to execution unit
id_enc  out  32  captured encoding
id_rs1  out  32  captured RS1
id_ready  in  1  execution unit accepts instruction
ex_done  in  1  execution finished
ex_wen  in  1  execution wants writeback
ex_wdata  in  32  execution write data
ex_result  in  3  execution result code
ex_abort  out  1  one-cycle abort pulse to execution unit

Behaviour:
- FSM states: IDLE, DISPATCH, EXEC, RESP.
- Reset (g_reset high at a clock edge): go to IDLE. Clear all capture and response registers to 0. All outputs are 0 while g_reset is high, including cop_insn_ack.
- Reset mid-operation: any in-flight instruction is dropped. No response and no ex_abort is issued.
- cop_insn_ack = (state==IDLE) && !g_reset. A request handshake fires on a cycle with cpu_insn_req && cop_insn_ack.
  - On the handshake: capture cpu_insn_enc and cpu_rs1.
  - The initiator holds req/enc/rs1 stable until ack.
  - After a handshake, a request still high on the next cycle while in IDLE is treated as a new instruction.
- Handshake with enc[6:0] != OPCODE_MATCH:
  - Go directly to RESP with result=010, wen=0, wdata=0.
  - The instruction is not dispatched.
- Handshake with enc[6:0] == OPCODE_MATCH: go to DISPATCH.
- DISPATCH:
  - id_valid=1; id_enc/id_rs1 come from the capture registers and are stable.
  - On id_ready, go to EXEC.
  - ex_done is ignored in DISPATCH.
- EXEC:
  - id_valid=0.
  - On ex_done: capture ex_wen, ex_wdata, ex_result into the response registers, then go to RESP.
- RESP:
  - cop_insn_rsp=1. cop_waddr = captured enc[11:7].
  - cop_wen = captured wen && result==000 && waddr!=0.
  - cop_wdata and cop_result come from the response registers.
  - All response outputs are held stable until cpu_insn_ack. On cpu_insn_ack, go to IDLE the next cycle.
- cop_insn_rsp, cop_wen and id_valid are 0 outside their states. cop_wdata, cop_waddr and cop_result outputs are 0 outside RESP.
- Minimum latencies (handshake cycle = 0, id_ready and ex_done asserted at first opportunity, cpu_insn_ack tied 1):
  - legal: DISPATCH @1, EXEC @2, RESP @3, IDLE @4.
  - illegal: RESP @1, IDLE @2.
- Only one instruction is outstanding; no new requests are accepted outside IDLE.

Optional Feature:
SCARV_COP_INSN_TIMEOUT_EN
- Defined:
  - A 16-bit counter clears on entry to EXEC and increments each EXEC cycle.
  - If the counter reaches TIMEOUT_CYCLES without ex_done: pulse ex_abort for 1 cycle and go to RESP with result=111, wen=0, wdata=0.
  - ex_done in the same cycle as expiry wins: normal completion, no abort.
- Undefined: no counter; ex_abort is tied 0; EXEC waits indefinitely.

Test Plan:
- Legal insn enc=0x0000058B (rd=11), rs1=0x12345678; id_ready=1 immediately; ex_done @2 with wen=1, wdata=0xDEADBEEF, result=000; cpu_insn_ack=1 -> rsp @3 with wen=1, waddr=11, wdata=0xDEADBEEF, result=000; IDLE @4.
- Illegal enc=0x00000033 -> cop_insn_ack @0, rsp @1 with result=010, wen=0; id_valid never asserted.
- Legal insn with rd=0, ex_wen=1 -> rsp with cop_wen=0, waddr=0. Legal insn with ex_result=001 -> cop_wen=0, result=001.
- Backpressure: id_ready low for 5 cycles, then cpu_insn_ack low for 4 rsp cycles -> id_valid/id_enc stable 5 cycles; response outputs stable 4 cycles; cop_insn_ack 0 throughout.
- g_reset pulsed for 1 cycle while in EXEC -> next cycle all outputs 0 except cop_insn_ack=1; no rsp; a subsequent instruction completes normally.
- With SCARV_COP_INSN_TIMEOUT_EN, TIMEOUT_CYCLES=8, ex_done never asserted -> ex_abort pulse after 8 EXEC cycles; rsp with result=111, wen=0.
